// File: rtl/booth_pkg.sv
// Shared types and helpers for the Booth multiplier arbiter.
// Holds the FSM state enum, picker result struct and rr_pick().
`ifndef N_BIT
`define N_BIT 8
`endif

package booth_pkg;

    localparam int MAX_CLIENT = 8;
    localparam int PTR_W      = 3;
    localparam int DEF_N      = `N_BIT;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        RESP
    } arb_state_t;

    typedef struct packed {
        logic             found;
        logic [PTR_W-1:0] idx;
    } rr_pick_t;

    // First set bit of req searching ptr+1, ptr+2, ... modulo n.
    // The last position visited is ptr itself, so the previous
    // winner has the lowest priority.
    function automatic rr_pick_t rr_pick(
        input logic [MAX_CLIENT-1:0] req,
        input logic [PTR_W-1:0]      ptr,
        input int                    n
    );
        rr_pick_t r;
        int       j;
        r = '0;
        for (int k = 1; k <= MAX_CLIENT; k++) begin
            j = (int'(ptr) + k) % n;
            if (k <= n && !r.found && req[j[PTR_W-1:0]]) begin
                r.found = 1'b1;
                r.idx   = j[PTR_W-1:0];
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/booth_arbiter_if.sv
// Bus bundle between clients, the arbiter and the shared multiplier.
// slave: arbiter view (clients/multiplier in, grants/results out);
// master: environment view (drives requests, operands and Done).
`ifndef N_BIT
`define N_BIT 8
`endif

interface booth_arbiter_if #(
    parameter int N_CLIENT = 4,
    parameter int N        = `N_BIT
);

    logic [N_CLIENT-1:0]   cli_req;
    logic [N_CLIENT*N-1:0] cli_op1;
    logic [N_CLIENT*N-1:0] cli_op2;
    logic [N_CLIENT-1:0]   cli_gnt;
    logic [N_CLIENT-1:0]   rsp_valid;
    logic [2*N-1:0]        rsp_result;
    logic                  rsp_err;
    logic                  busy;
    logic                  mult_request;
    logic [N-1:0]          mult_op1;
    logic [N-1:0]          mult_op2;
    logic                  mult_done;
    logic [2*N-1:0]        mult_result;

    modport slave (
        input  cli_req,
        input  cli_op1,
        input  cli_op2,
        input  mult_done,
        input  mult_result,
        output cli_gnt,
        output rsp_valid,
        output rsp_result,
        output rsp_err,
        output busy,
        output mult_request,
        output mult_op1,
        output mult_op2
    );

    modport master (
        output cli_req,
        output cli_op1,
        output cli_op2,
        output mult_done,
        output mult_result,
        input  cli_gnt,
        input  rsp_valid,
        input  rsp_result,
        input  rsp_err,
        input  busy,
        input  mult_request,
        input  mult_op1,
        input  mult_op2
    );

endinterface

// File: rtl/booth_arbiter_rr_picker.sv
// Combinational round-robin priority search over the request vector.
// Ports: req (requests), ptr (last winner) -> found, idx (winner).
module rr_picker
    import booth_pkg::*;
#(
    parameter int N_CLIENT = 4
) (
    input  logic [N_CLIENT-1:0]         req,
    input  logic [$clog2(N_CLIENT)-1:0] ptr,
    output logic                        found,
    output logic [$clog2(N_CLIENT)-1:0] idx
);

    localparam int IDX_W = $clog2(N_CLIENT);

    logic [MAX_CLIENT-1:0] req_w;
    logic [PTR_W-1:0]      ptr_w;
    rr_pick_t              pick;

    always_comb begin
        req_w = MAX_CLIENT'(req);
        ptr_w = PTR_W'(ptr);
        pick  = rr_pick(req_w, ptr_w, N_CLIENT);
        found = pick.found;
        idx   = IDX_W'(pick.idx);
    end

endmodule

// File: rtl/booth_arbiter.sv
// Round-robin arbiter sharing one Booth multiplier among N_CLIENT clients.
// Ports: clk, rst (sync, active-high), bus (booth_arbiter_if.slave).
`ifndef N_BIT
`define N_BIT 8
`endif

module booth_arbiter
    import booth_pkg::*;
#(
    parameter int N_CLIENT = 4,
    parameter int N        = `N_BIT,
    parameter int TIMEOUT  = 64
) (
    input logic           clk,
    input logic           rst,
    booth_arbiter_if.slave bus
);

    localparam int IDX_W = $clog2(N_CLIENT);
    localparam int WD_W  = $clog2(TIMEOUT);

    arb_state_t state;
    arb_state_t state_nx;

    logic [IDX_W-1:0]    rr_ptr;
    logic [IDX_W-1:0]    ptr_d;
    logic [WD_W-1:0]     wdog;
    logic [WD_W-1:0]     wdog_d;
    logic [N_CLIENT-1:0] gnt_q;
    logic [N_CLIENT-1:0] gnt_d;
    logic [N_CLIENT-1:0] rv_q;
    logic [N_CLIENT-1:0] rv_d;
    logic [2*N-1:0]      res_q;
    logic [2*N-1:0]      res_d;
    logic                err_q;
    logic                err_d;
    logic                busy_q;
    logic                busy_d;
    logic                req_q;
    logic                req_d;
    logic [N-1:0]        op1_q;
    logic [N-1:0]        op1_d;
    logic [N-1:0]        op2_q;
    logic [N-1:0]        op2_d;

    logic             pick_found;
    logic [IDX_W-1:0] pick_idx;
    logic             done_ok;
    logic             timed_out;

    rr_picker #(
        .N_CLIENT (N_CLIENT)
    ) u_picker (
        .req   (bus.cli_req),
        .ptr   (rr_ptr),
        .found (pick_found),
        .idx   (pick_idx)
    );

    // Request is registered out of ISSUE, so it is on the wire during
    // the first WAIT cycle. A Done seen in that cycle predates our
    // Request and must be stale, so it is not accepted.
    always_comb begin
        done_ok   = bus.mult_done && !req_q;
        timed_out = (wdog == WD_W'(TIMEOUT - 1));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:  if (pick_found) state_nx = ISSUE;
            ISSUE: state_nx = WAIT;
            WAIT:  if (done_ok || timed_out) state_nx = RESP;
            RESP:  state_nx = IDLE;
        endcase
    end

    // Next values of the registered outputs; rr_ptr doubles as the
    // index of the client currently being served.
    always_comb begin
        gnt_d  = '0;
        rv_d   = '0;
        req_d  = 1'b0;
        busy_d = (state_nx != IDLE);
        res_d  = res_q;
        err_d  = err_q;
        op1_d  = op1_q;
        op2_d  = op2_q;
        ptr_d  = rr_ptr;
        wdog_d = wdog;
        unique case (state)
            IDLE: begin
                if (pick_found) begin
                    gnt_d[pick_idx] = 1'b1;
                    ptr_d  = pick_idx;
                    op1_d  = bus.cli_op1[int'(pick_idx)*N +: N];
                    op2_d  = bus.cli_op2[int'(pick_idx)*N +: N];
                    wdog_d = '0;
                end
            end
            ISSUE: begin
                req_d  = 1'b1;
                wdog_d = '0;
            end
            WAIT: begin
                wdog_d = wdog + 1'b1;
                if (done_ok) begin
                    rv_d[rr_ptr] = 1'b1;
                    res_d = bus.mult_result;
                    err_d = 1'b0;
                end else if (timed_out) begin
                    rv_d[rr_ptr] = 1'b1;
                    res_d = '0;
                    err_d = 1'b1;
                end
            end
            RESP: begin
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr <= IDX_W'(N_CLIENT - 1);
            wdog   <= '0;
            gnt_q  <= '0;
            rv_q   <= '0;
            res_q  <= '0;
            err_q  <= 1'b0;
            busy_q <= 1'b0;
            req_q  <= 1'b0;
            op1_q  <= '0;
            op2_q  <= '0;
        end else begin
            rr_ptr <= ptr_d;
            wdog   <= wdog_d;
            gnt_q  <= gnt_d;
            rv_q   <= rv_d;
            res_q  <= res_d;
            err_q  <= err_d;
            busy_q <= busy_d;
            req_q  <= req_d;
            op1_q  <= op1_d;
            op2_q  <= op2_d;
        end
    end

    assign bus.cli_gnt      = gnt_q;
    assign bus.rsp_valid    = rv_q;
    assign bus.rsp_result   = res_q;
    assign bus.rsp_err      = err_q;
    assign bus.busy         = busy_q;
    assign bus.mult_request = req_q;
    assign bus.mult_op1     = op1_q;
    assign bus.mult_op2     = op2_q;

endmodule
